// File: rtl/stress_trend.sv
// stress_trend: per-channel quantised falling-trend detector.
// Each channel keeps the top KEEP_BITS bits of its sample, counts consecutive
// drops (saturating at HOLD), and raises a falling flag once HOLD drops have
// been seen. The flags are combined in any-channel or all-channel mode into a
// registered calming indicator plus a one-cycle rising-edge pulse.
module stress_trend #(
  parameter int WIDTH     = 8,
  parameter int CHANNELS  = 2,
  parameter int KEEP_BITS = 3,
  parameter int HOLD      = 1
) (
  input  logic                      clk,
  input  logic                      r,
  input  logic                      sample_en,
  input  logic [CHANNELS*WIDTH-1:0] sample,
  input  logic                      mode_all,
  output logic [CHANNELS-1:0]       falling,
  output logic                      stress_low,
  output logic                      stress_low_pulse
);

  // Counter just wide enough to hold the value HOLD (at least one bit).
  localparam int CW = ($clog2(HOLD + 1) < 1) ? 1 : $clog2(HOLD + 1);
  localparam logic [CW-1:0] HOLD_C = CW'(HOLD);

  logic [CHANNELS-1:0][WIDTH-1:0]     chan_s;
  logic [CHANNELS-1:0][KEEP_BITS-1:0] q_s;

  logic [CHANNELS-1:0][KEEP_BITS-1:0] prev_q, prev_d;
  logic [CHANNELS-1:0]                have_prev_q, have_prev_d;
  logic [CHANNELS-1:0][CW-1:0]        cnt_q, cnt_d;
  logic [CHANNELS-1:0]                falling_q, falling_d;

  logic comb_s;
  logic stress_low_q, stress_low_d;
  logic pulse_q, pulse_d;

  // Per-channel quantisation and next-state for history, drop count and flag.
  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      chan_s[i]      = sample[i*WIDTH +: WIDTH];
      // Shifting the whole raw sample keeps only its KEEP_BITS MSBs.
      q_s[i]         = KEEP_BITS'(chan_s[i] >> (WIDTH - KEEP_BITS));
      prev_d[i]      = prev_q[i];
      have_prev_d[i] = have_prev_q[i];
      cnt_d[i]       = cnt_q[i];
      falling_d[i]   = falling_q[i];
      if (sample_en) begin
        if (!have_prev_q[i]) begin
          // First sample after reset only seeds the history.
          prev_d[i]      = q_s[i];
          have_prev_d[i] = 1'b1;
        end else begin
          if (q_s[i] < prev_q[i]) begin
            if (cnt_q[i] == HOLD_C) begin
              cnt_d[i] = HOLD_C;
            end else begin
              cnt_d[i] = cnt_q[i] + CW'(1);
            end
          end else if (q_s[i] > prev_q[i]) begin
            cnt_d[i] = {CW{1'b0}};
          end else begin
            cnt_d[i] = cnt_q[i];
          end
          prev_d[i]    = q_s[i];
          // Flag follows the freshly updated count on the same edge.
          falling_d[i] = (cnt_d[i] == HOLD_C);
        end
      end else begin
        prev_d[i]      = prev_q[i];
        have_prev_d[i] = have_prev_q[i];
        cnt_d[i]       = cnt_q[i];
        falling_d[i]   = falling_q[i];
      end
    end
  end

  // Combine registered channel flags and derive the rising-edge pulse.
  always_comb begin
    comb_s = 1'b0;
    if (mode_all) begin
      comb_s = &falling_q;
    end else begin
      comb_s = |falling_q;
    end
    stress_low_d = comb_s;
    pulse_d      = comb_s & ~stress_low_q;
  end

  // Channel history, counters and flags; cleared asynchronously by r.
  always_ff @(posedge clk or negedge r) begin
    if (!r) begin
      prev_q      <= '{default: {KEEP_BITS{1'b0}}};
      have_prev_q <= {CHANNELS{1'b0}};
      cnt_q       <= '{default: {CW{1'b0}}};
      falling_q   <= {CHANNELS{1'b0}};
    end else begin
      prev_q      <= prev_d;
      have_prev_q <= have_prev_d;
      cnt_q       <= cnt_d;
      falling_q   <= falling_d;
    end
  end

  // Combined indicator and its one-cycle pulse; cleared asynchronously by r.
  always_ff @(posedge clk or negedge r) begin
    if (!r) begin
      stress_low_q <= 1'b0;
      pulse_q      <= 1'b0;
    end else begin
      stress_low_q <= stress_low_d;
      pulse_q      <= pulse_d;
    end
  end

  assign falling          = falling_q;
  assign stress_low       = stress_low_q;
  assign stress_low_pulse = pulse_q;

endmodule

// File: doc/stress_trend.md
# stress_trend

Parametrised successor of the two-channel stress-drop detector. Watches CHANNELS sampled sensor values, such as cry volume and heart rate, each quantised to its top KEEP_BITS bits. It flags a channel as falling once its quantised value has dropped on HOLD consecutive accepted samples. Channel flags are combined in any-channel or all-channel mode into a registered calming indicator (`stress_low`) plus a one-cycle rising-edge pulse, which feed the rocking controller.

## Interface
- WIDTH, 8, bit width of each raw channel sample
- CHANNELS, 2, number of monitored channels (≥1)
- KEEP_BITS, 3, number of MSBs kept per sample for comparison (1..WIDTH)
- HOLD, 1, consecutive quantised drops needed to assert a channel's falling flag (≥1)
- clk  in  1  system clock, all state on rising edge
- r  in  1  reset, asynchronous, active-low
- sample_en  in  1  accept `sample` on this edge (all channels together)
- sample  in  CHANNELS*WIDTH  packed raw samples, channel i at [i*WIDTH +: WIDTH]
- mode_all  in  1  0: stress_low if any channel falling; 1: only if all channels falling
- falling  out  CHANNELS  per-channel falling flag, registered
- stress_low  out  1  combined calming indicator, registered
- stress_low_pulse  out  1  one-cycle pulse on a stress_low 0→1 transition

## Operation
- Per channel, `q = sample[i*WIDTH + WIDTH-1 -: KEEP_BITS]`, unsigned; the low bits are ignored.
- Per-channel state: `prev` (KEEP_BITS), `have_prev` (1), `cnt` (width `$clog2(HOLD+1)`, minimum 1), and the `falling` flag.
- Reset (r=0) clears all of the following, immediately and asynchronously: `prev`=0, `have_prev`=0, `cnt`=0, `falling`=0, `stress_low`=0, `stress_low_pulse`=0.
- Edges with `sample_en`=0 leave channel state unchanged.
- Edges with `sample_en`=1, per channel:
  - `have_prev`=0: load `prev`=q and set `have_prev`=1. `cnt` and `falling` are unchanged (both stay 0). The first sample after reset never counts as a drop.
  - q < prev: set `cnt` = min(cnt+1, HOLD), saturating.
  - q == prev: `cnt` is unchanged.
  - q > prev: `cnt`=0.
  - In all three compared cases, `prev`=q.
  - `falling` is set to (next cnt == HOLD), i.e. it is computed from the updated count on the same edge.
- Combine, evaluated every cycle from the registered `falling`: `comb` = mode_all ? &falling : |falling. Then `stress_low` <= comb.
- `stress_low_pulse` <= comb & ~stress_low. It is high for exactly one cycle per rising transition.
- `mode_all` may change at any time. The effect appears on the next edge and can itself generate a pulse.
- No other outputs exist. There is no gating of outputs with clk; every output is a plain flop.

## Timing
- Latency: sample accepted at edge k → `falling` updated after edge k → `stress_low`/`stress_low_pulse` updated after edge k+1.
- With HOLD=1, a single quantised drop asserts `falling` one edge later and `stress_low` two edges later.
- A rise or an equal sample does not clear `stress_low` until the next edge after `falling` changes. An equal sample keeps `falling` asserted.
- Back-to-back `sample_en` every cycle is supported at full rate.
- Reset asserted mid-sequence discards all history. The first post-reset sample is load-only.
- The pulse cannot repeat while `stress_low` stays high. The edge after a deassertion may pulse again if comb returns to 1.

## Test plan
- **Reset / first sample**, defaults: hold r=0, release, then sample_en with ch0=0xE0, ch1=0xC0 → all outputs 0. The next sample ch0=0xA0 → falling[0]=1 after 1 edge, stress_low=1 and pulse=1 for one cycle after 2 edges.
- **Quantisation**: ch0 0xFF→0xE1 (same top 3 bits, 7→7) → falling[0] stays 0. Then 0xE1→0xDF (7→6) → falling[0]=1.
- **HOLD=3**: ch0 quantised 7,6,6,5,4 → falling[0] rises only after the sample 4. The equal 6 neither resets nor advances the count. A following 5 → cnt=0, falling[0]=0, and stress_low=0 one edge later.
- **Mode**: ch0 falling, ch1 steady, mode_all=0 → stress_low=1. Switch mode_all=1 → stress_low=0 next edge. Drop ch1 → falling=2'b11, stress_low=1, and pulse=1 once.
- **Reset mid-operation**: with stress_low=1, pull r low for one cycle → all outputs 0 immediately. The next sample is load-only, so falling stays 0 even if it is lower than the pre-reset value.
- **sample_en gating**: sample changes to a lower value with sample_en=0 for 5 cycles → no output change. Assert sample_en once → one decrement counted.
